// File: rtl/sha_round_ctrl.sv
// sha_round_ctrl: SHA-2 round controller with chained multi-block intake and digest hold.
// Define SHA_ROUND_CTRL_ABORT_EN to make abort cancel a message in progress.
module sha_round_ctrl #(
  parameter int ROUNDS     = 64,
  parameter int ROUND_W    = 7,
  parameter int PRE_CYCLES = 1,
  parameter int BLK_W      = 8
) (
  input  logic               clk_fsm,
  input  logic               rst_fsm_n,
  input  logic               block_valid,
  input  logic               block_last,
  output logic               block_ready,
  input  logic               digest_ack,
  input  logic               abort,
  output logic               load_block,
  output logic               init_h,
  output logic               rotate_W,
  output logic               round_enable,
  output logic [ROUND_W-1:0] round,
  output logic               enable_last_addition,
  output logic               digest_valid,
  output logic               busy,
  output logic [BLK_W-1:0]   blk_count
);
  localparam int PRE_W = PRE_CYCLES > 1 ? $clog2(PRE_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, PRE, RND, LAST_ADD, WAIT_BLK, RESULT} state_t;
  state_t state, nxt;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic [ROUND_W-1:0] round_nxt;
  logic [BLK_W-1:0] blk_nxt;
  logic last_flag, last_nxt, accept, kill, load_nxt;
  assign accept = block_valid & block_ready;
`ifdef SHA_ROUND_CTRL_ABORT_EN
  assign kill = abort & (state != IDLE);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign kill = 1'b0;
`endif
  always_comb begin
    nxt = state;
    pre_nxt = '0;
    round_nxt = '0;
    blk_nxt = blk_count;
    last_nxt = last_flag;
    case (state)
      IDLE, WAIT_BLK: if (accept) begin
        nxt = PRE;
        last_nxt = block_last;
        blk_nxt = state == IDLE ? BLK_W'(1) : (&blk_count ? blk_count : blk_count + BLK_W'(1));
      end
      PRE: begin
        pre_nxt = pre_cnt + PRE_W'(1);
        if (pre_cnt == PRE_W'(PRE_CYCLES - 1)) nxt = RND;
      end
      RND: begin
        round_nxt = round + ROUND_W'(1);
        if (round == ROUND_W'(ROUNDS - 1)) begin
          nxt = LAST_ADD;
          round_nxt = '0;
        end
      end
      LAST_ADD: nxt = last_flag ? RESULT : WAIT_BLK;
      RESULT: if (digest_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) begin
      nxt = IDLE;
      round_nxt = '0;
      blk_nxt = '0;
    end
    load_nxt = nxt == PRE && (state == IDLE || state == WAIT_BLK);
  end
  // outputs are registered from the next state so they align with it
  always_ff @(posedge clk_fsm) begin
    if (!rst_fsm_n) begin
      state <= IDLE;
      pre_cnt <= '0;
      last_flag <= 1'b0;
      block_ready <= 1'b0;
      load_block <= 1'b0;
      init_h <= 1'b0;
      rotate_W <= 1'b0;
      round_enable <= 1'b0;
      round <= '0;
      enable_last_addition <= 1'b0;
      digest_valid <= 1'b0;
      busy <= 1'b0;
      blk_count <= '0;
    end else begin
      state <= nxt;
      pre_cnt <= pre_nxt;
      last_flag <= last_nxt;
      block_ready <= nxt == IDLE || nxt == WAIT_BLK;
      load_block <= load_nxt;
      init_h <= load_nxt && blk_nxt == BLK_W'(1);
      rotate_W <= nxt == PRE || nxt == RND;
      round_enable <= nxt == RND;
      round <= round_nxt;
      enable_last_addition <= nxt == LAST_ADD;
      digest_valid <= nxt == RESULT;
      busy <= nxt != IDLE;
      blk_count <= blk_nxt;
    end
  end
endmodule

// File: tb/tb_sha_round_ctrl.sv
// tb_sha_round_ctrl: scoreboard bench for sha_round_ctrl (default and ROUNDS=80/PRE_CYCLES=3 builds).
module tb_sha_round_ctrl;
  logic clk_fsm = 1'b0;
  logic rst_fsm_n = 1'b0;
  logic block_valid = 1'b0, block_last = 1'b0, digest_ack = 1'b0, abort = 1'b0;
  logic block_ready, load_block, init_h, rotate_W, round_enable, enable_last_addition, digest_valid, busy;
  logic [6:0] round;
  logic [7:0] blk_count;
  logic valid2 = 1'b0, last2 = 1'b0, ack2 = 1'b0;
  logic ready2, load2, ih2, rw2, re2, ela2, dv2, busy2;
  logic [6:0] round2;
  logic [7:0] bc2;
  logic [22:0] obs, e;
  logic [22:0] sb[$];
  int total = 0, bad = 0;

  always #5 clk_fsm = ~clk_fsm;

  sha_round_ctrl dut (
    .clk_fsm(clk_fsm), .rst_fsm_n(rst_fsm_n), .block_valid(block_valid), .block_last(block_last),
    .block_ready(block_ready), .digest_ack(digest_ack), .abort(abort), .load_block(load_block),
    .init_h(init_h), .rotate_W(rotate_W), .round_enable(round_enable), .round(round),
    .enable_last_addition(enable_last_addition), .digest_valid(digest_valid), .busy(busy),
    .blk_count(blk_count)
  );

  sha_round_ctrl #(.ROUNDS(80), .ROUND_W(7), .PRE_CYCLES(3), .BLK_W(8)) dut2 (
    .clk_fsm(clk_fsm), .rst_fsm_n(rst_fsm_n), .block_valid(valid2), .block_last(last2),
    .block_ready(ready2), .digest_ack(ack2), .abort(1'b0), .load_block(load2),
    .init_h(ih2), .rotate_W(rw2), .round_enable(re2), .round(round2),
    .enable_last_addition(ela2), .digest_valid(dv2), .busy(busy2), .blk_count(bc2)
  );

  assign obs = {block_ready, load_block, init_h, rotate_W, round_enable, round,
                enable_last_addition, digest_valid, busy, blk_count};

  task automatic push_v(input logic br, lb, ih, rw, re, input logic [6:0] r,
                        input logic ela, dv, bsy, input logic [7:0] bc);
    sb.push_back({br, lb, ih, rw, re, r, ela, dv, bsy, bc});
  endtask
  task automatic push_zero();
    push_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask
  task automatic push_idle(input logic [7:0] bc);
    push_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, bc);
  endtask
  task automatic push_wait(input logic [7:0] bc);
    push_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, bc);
  endtask
  task automatic push_pre(input logic first, input logic [7:0] bc);
    push_v(1'b0, 1'b1, first, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, bc);
  endtask
  task automatic push_rnds(input int a, input int b, input logic [7:0] bc);
    for (int i = a; i <= b; i++) push_v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'(i), 1'b0, 1'b0, 1'b1, bc);
  endtask
  task automatic push_la(input logic [7:0] bc);
    push_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, bc);
  endtask
  task automatic push_res(input logic [7:0] bc);
    push_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1, bc);
  endtask

  task automatic test_reset();
    int c = 0;
    push_zero(); push_zero(); push_idle(8'd0);
    while (sb.size() > 0) begin
      @(negedge clk_fsm); c++;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset c=%0d got=%h exp=%h", c, obs, e); end
      if (c == 2) rst_fsm_n = 1'b1;
    end
  endtask

  task automatic test_single();
    int c = 0;
    block_valid = 1'b1; block_last = 1'b1;
    push_pre(1'b1, 8'd1); push_rnds(0, 63, 8'd1); push_la(8'd1);
    repeat (3) push_res(8'd1);
    push_idle(8'd1);
    while (sb.size() > 0) begin
      @(negedge clk_fsm); c++;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL single c=%0d got=%h exp=%h", c, obs, e); end
      if (c == 1) block_valid = 1'b0;
      if (c == 69) digest_ack = 1'b1;
      if (c == 70) digest_ack = 1'b0;
    end
  endtask

  task automatic test_two_block();
    int c = 0;
    block_valid = 1'b1; block_last = 1'b0;
    push_pre(1'b1, 8'd1); push_rnds(0, 63, 8'd1); push_la(8'd1);
    repeat (6) push_wait(8'd1);
    push_pre(1'b0, 8'd2); push_rnds(0, 63, 8'd2); push_la(8'd2);
    repeat (2) push_res(8'd2);
    push_idle(8'd2);
    while (sb.size() > 0) begin
      @(negedge clk_fsm); c++;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL two_block c=%0d got=%h exp=%h", c, obs, e); end
      if (c == 1) block_valid = 1'b0;
      if (c == 72) begin block_valid = 1'b1; block_last = 1'b1; end
      if (c == 73) block_valid = 1'b0;
      if (c == 140) digest_ack = 1'b1;
      if (c == 141) digest_ack = 1'b0;
    end
  endtask

  task automatic test_digest_hold();
    int c = 0;
    block_valid = 1'b1; block_last = 1'b1;
    push_pre(1'b1, 8'd1); push_rnds(0, 63, 8'd1); push_la(8'd1);
    repeat (20) push_res(8'd1);
    push_idle(8'd1);
    push_pre(1'b1, 8'd1); push_rnds(0, 63, 8'd1); push_la(8'd1); push_res(8'd1);
    push_idle(8'd1);
    while (sb.size() > 0) begin
      @(negedge clk_fsm); c++;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL digest_hold c=%0d got=%h exp=%h", c, obs, e); end
      if (c == 86 || c == 154) digest_ack = 1'b1;
      if (c == 87 || c == 155) digest_ack = 1'b0;
      if (c == 88) block_valid = 1'b0;
    end
  endtask

  task automatic test_long_rounds();
    int ek[$], ec[$];
    int k, xk, xc;
    logic dv_d = 1'b0;
    total++;
    if (ready2 !== 1'b1) begin bad++; $display("FAIL long_ready got=%b exp=1", ready2); end
    valid2 = 1'b1; last2 = 1'b1;
    ek.push_back(0); ec.push_back(1);
    ek.push_back(1); ec.push_back(83);
    ek.push_back(2); ec.push_back(84);
    ek.push_back(3); ec.push_back(85);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk_fsm);
      if (c == 1) valid2 = 1'b0;
      k = load2 ? 0 : (re2 && round2 == 7'd79) ? 1 : ela2 ? 2 : (dv2 && !dv_d) ? 3 : -1;
      dv_d = dv2;
      if (k >= 0) begin
        total++;
        if (ek.size() == 0) begin bad++; $display("FAIL long_extra c=%0d event=%0d exp=none", c, k); end
        else begin
          xk = ek.pop_front(); xc = ec.pop_front();
          if (k != xk || c != xc) begin
            bad++; $display("FAIL long_event got=%0d@%0d exp=%0d@%0d", k, c, xk, xc);
          end
        end
      end
      if (c == 86) ack2 = 1'b1;
      if (c == 87) ack2 = 1'b0;
    end
    total++;
    if (ek.size() != 0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL long_end missing=%0d busy=%b exp=0/0", ek.size(), busy2);
    end
  endtask

`ifdef SHA_ROUND_CTRL_ABORT_EN
  localparam int ACK_C = 80;
`else
  localparam int ACK_C = 67;
`endif

  task automatic test_abort();
    int c = 0;
    block_valid = 1'b1; block_last = 1'b1;
    push_pre(1'b1, 8'd1); push_rnds(0, 10, 8'd1);
`ifdef SHA_ROUND_CTRL_ABORT_EN
    push_idle(8'd0);
    push_pre(1'b1, 8'd1); push_rnds(0, 63, 8'd1);
`else
    push_rnds(11, 63, 8'd1);
`endif
    push_la(8'd1); push_res(8'd1); push_idle(8'd1);
    while (sb.size() > 0) begin
      @(negedge clk_fsm); c++;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL abort c=%0d got=%h exp=%h", c, obs, e); end
      if (c == 1) block_valid = 1'b0;
      if (c == 12) abort = 1'b1;
`ifdef SHA_ROUND_CTRL_ABORT_EN
      if (c == 13) block_valid = 1'b1;
      if (c == 14) begin block_valid = 1'b0; abort = 1'b0; end
`else
      if (c == 13) abort = 1'b0;
`endif
      if (c == ACK_C) digest_ack = 1'b1;
      if (c == ACK_C + 1) digest_ack = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    block_valid = 1'b1; block_last = 1'b1;
    push_pre(1'b1, 8'd1); push_rnds(0, 30, 8'd1);
    push_zero(); push_idle(8'd0);
    while (sb.size() > 0) begin
      @(negedge clk_fsm); c++;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, e); end
      if (c == 1) block_valid = 1'b0;
      if (c == 32) rst_fsm_n = 1'b0;
      if (c == 33) rst_fsm_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_block();
    test_digest_hold();
    test_long_rounds();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha_round_ctrl.md
Name: sha_round_ctrl

Overview:
Parametrised control FSM for the SHA-2 compression datapath, and the successor to the single-block round controller. Differences from the single-block version:
- round count and pipeline pre-fill depth are parameters;
- multi-block messages are chained, with valid/ready block intake;
- digest hold uses an explicit acknowledge;
- the FSM returns to IDLE after each message instead of parking in RESULT.
It drives the message schedule (rotate_W), the round counter and the H-register final addition.

Parameters:
ROUNDS, 64, compression rounds per block (64 for SHA-256, 80 for SHA-512).
ROUND_W, 7, width of round output; must satisfy 2**ROUND_W >= ROUNDS.
PRE_CYCLES, 1, schedule pre-fill cycles before round 0 (>=1).
BLK_W, 8, width of blk_count.

Ports:
clk_fsm  in  1  FSM clock, rising edge.
rst_fsm_n  in  1  synchronous active-low reset.
block_valid  in  1  message block available at datapath input.
block_last  in  1  qualifies block_valid; block is final block of message.
block_ready  out  1  FSM accepts a block this cycle.
digest_ack  in  1  consumer has taken the digest.
abort  in  1  cancel current message (see Optional Feature).
load_block  out  1  one-cycle pulse: datapath loads the accepted block into W.
init_h  out  1  one-cycle pulse with load_block on the first block: load IV into H.
rotate_W  out  1  schedule shift enable.
round_enable  out  1  round counter / compression enable.
round  out  ROUND_W  current round index.
enable_last_addition  out  1  H += working vars.
digest_valid  out  1  digest stable on H.
busy  out  1  high in every state except IDLE.
blk_count  out  BLK_W  number of blocks accepted in current message.

Behaviour:
- One clock. Reset is synchronous and active-low (rst_fsm_n sampled on rising clk_fsm). Reset overrides all other inputs.
- Reset values: every output is 0 and state is IDLE. block_ready rises the first cycle after reset release.
- All outputs are registered from next state.
- States and transitions:
  - IDLE: block_ready=1. On block_valid&block_ready → PRE. Latch last_flag=block_last; blk_count<=1.
  - PRE: lasts PRE_CYCLES cycles. rotate_W=1. load_block=1 on the first PRE cycle only. init_h=1 on that cycle if blk_count==1. Then → RND.
  - RND: lasts exactly ROUNDS cycles. round_enable=1, rotate_W=1. round = 0 on the first RND cycle, incrementing to ROUNDS-1 on the last. Then → LAST_ADD.
  - LAST_ADD: 1 cycle, enable_last_addition=1, round<=0. If last_flag → RESULT, else → WAIT_BLK.
  - WAIT_BLK: block_ready=1. On accept → PRE. Latch last_flag; blk_count increments, saturating at all-ones.
  - RESULT: digest_valid=1, held until digest_ack. On digest_ack → IDLE (digest_valid=0 next cycle). block_ready=0 in RESULT, so a simultaneous block_valid is not accepted.
- Latency: accept at cycle T gives load_block at T+1, round 0 at T+1+PRE_CYCLES, enable_last_addition at T+1+PRE_CYCLES+ROUNDS, digest_valid from T+2+PRE_CYCLES+ROUNDS.
- block_ready is 0 in PRE, RND, LAST_ADD and RESULT. block_valid in those states is ignored and not queued.
- blk_count holds its value through RESULT and clears only on the next IDLE accept.
- digest_ack outside RESULT is ignored.
- Reset mid-operation returns to IDLE the next cycle. Pulses are dropped and no digest_valid is produced.

Optional Feature:
SHA_ROUND_CTRL_ABORT_EN.
- Defined: abort=1 in any non-IDLE state forces IDLE the next cycle. All pulse outputs are 0 that cycle, round=0, blk_count cleared, digest_valid dropped. Abort in IDLE is ignored. Abort and an accept in the same IDLE cycle: the accept wins.
- Undefined: the abort port exists but is ignored. The FSM has no abort logic.

Test Plan:
- Single block, defaults: block_valid=1, block_last=1 accepted at cycle 0 → expected response:
  - load_block and init_h at 1;
  - round_enable cycles 2..65, round 0..63;
  - enable_last_addition at 66;
  - digest_valid from 67 until digest_ack; IDLE and block_ready=1 the cycle after ack.
- Two-block message, defaults:
  - block 1 is accepted with block_last=0, and the FSM enters WAIT_BLK after LAST_ADD.
  - Block 2 is presented 5 cycles late: init_h=0 on the second load_block, and blk_count=2.
  - digest_valid asserts only after block 2's last addition.
- Parameters ROUNDS=80, ROUND_W=7, PRE_CYCLES=3: single block → round reaches 79; enable_last_addition exactly 84 cycles after accept.
- Digest hold: digest_ack withheld 20 cycles with block_valid=1 → digest_valid steady and block_ready=0 throughout; the block is accepted only after returning to IDLE.
- Reset mid-run: rst_fsm_n=0 at round 30 → all outputs 0 the next cycle; after release, block_ready=1 and round=0.
- Abort at round 10 with SHA_ROUND_CTRL_ABORT_EN defined → IDLE next cycle, no enable_last_addition, no digest_valid. With the macro undefined, the same stimulus completes normally.
